// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit CPU control path: opcodes, FSM states, ALU functions.
package cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_MOV = 4'h6;
  localparam logic [3:0] OP_LDI = 4'h7;
  localparam logic [3:0] OP_LD  = 4'h8;
  localparam logic [3:0] OP_ST  = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hA;
  localparam logic [3:0] OP_JZ  = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_PASS = 3'd5;

  // MOV and LDI route operand B straight through the ALU.
  function automatic logic [2:0] alu_sel(input logic [3:0] op);
    case (op)
      OP_SUB:         alu_sel = ALU_SUB;
      OP_AND:         alu_sel = ALU_AND;
      OP_OR:          alu_sel = ALU_OR;
      OP_XOR:         alu_sel = ALU_XOR;
      OP_MOV, OP_LDI: alu_sel = ALU_PASS;
      default:        alu_sel = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/cpu_mem_watchdog.sv
// Memory-request watchdog: counts consecutive pending cycles and flags the one
// that reaches TIMEOUT without an ack.
module cpu_mem_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic ack,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;

  // An ack in the final allowed cycle wins over expiry.
  assign expired = req && !ack && (cnt == W'(TIMEOUT - 1));

  // Any cycle without a pending request (or with its ack) restarts the count,
  // so each new FETCH/MEM request begins from zero.
  always_ff @(posedge clk) begin
    if (!rst)                       cnt <= '0;
    else if (req && !ack && !expired) cnt <= cnt + 1'b1;
    else                            cnt <= '0;
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control unit: fetch/decode/exec/mem/wb sequencing, memory
// handshakes with timeout, and a retired-instruction counter.
module cpu_ctrl_fsm
  import cpu_pkg::*;
#(
  parameter int OPC_W   = 4,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             rf_we,
  output logic [2:0]       alu_op,
  output logic             wb_sel,
  output logic             halted,
  output logic             bus_err,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count,
  output logic [2:0]       state
);

  logic [3:0] op;
  logic [2:0] nxt;
  logic       is_alu, is_mem, is_ill, retire, expired, wd_ack;

  assign op     = opcode[3:0];
  assign is_alu = (op >= OP_ADD) && (op <= OP_LDI);
  assign is_mem = (op == OP_LD) || (op == OP_ST);
  assign is_ill = (op >= 4'hC) && (op <= 4'hE);
  assign wd_ack = (state == S_MEM) ? dmem_ack : imem_ack;
  assign halted = (state == S_HALT);

  cpu_mem_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .req     (imem_req | dmem_req),
    .ack     (wd_ack),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_FETCH;
      bus_err     <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= nxt;
      if (expired) bus_err <= 1'b1;
      if (retire)  instr_count <= instr_count + 1'b1;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      S_FETCH:  if (imem_ack) nxt = S_DECODE;
                else if (expired) nxt = S_HALT;
      S_DECODE: nxt = S_EXEC;
      S_EXEC: begin
        if (is_alu)            nxt = S_WB;
        else if (is_mem)       nxt = S_MEM;
        else if (op == OP_HLT) nxt = S_HALT;
        else                   nxt = S_FETCH;
      end
      S_MEM:    if (dmem_ack) nxt = (op == OP_LD) ? S_WB : S_FETCH;
                else if (expired) nxt = S_HALT;
      S_WB:     nxt = S_FETCH;
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_FETCH;
    endcase
  end

  // Every strobe is held low while reset is asserted, whatever the state.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_load  = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    rf_we    = 1'b0;
    alu_op   = ALU_ADD;
    wb_sel   = 1'b0;
    illegal  = 1'b0;
    retire   = 1'b0;
    if (rst) begin
      case (state)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_load  = imem_ack;
        end
        S_EXEC: begin
          retire = !is_alu && !is_mem;
          if (is_alu) alu_op = alu_sel(op);
          if (op == OP_JMP) pc_load = 1'b1;
          else if (op == OP_JZ) begin
            pc_load = zero;
            pc_inc  = !zero;
          end else if (!is_alu && !is_mem && op != OP_HLT) begin
            pc_inc  = 1'b1;
            illegal = is_ill;
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (op == OP_ST);
          wb_sel   = (op == OP_LD);
          pc_inc   = (op == OP_ST) && dmem_ack;
          retire   = (op == OP_ST) && dmem_ack;
        end
        S_WB: begin
          rf_we  = 1'b1;
          pc_inc = 1'b1;
          wb_sel = (op == OP_LD);
          retire = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench: each instruction is expanded into its expected per-cycle
// trace from ack delays, then driven and compared cycle by cycle.
module tb_cpu_ctrl_fsm;
  localparam int TO = 15;
  localparam int CW = 4;

  localparam logic [9:0] IREQ = 10'b1000000000;
  localparam logic [9:0] IRLD = 10'b0100000000;
  localparam logic [9:0] DREQ = 10'b0010000000;
  localparam logic [9:0] DWE  = 10'b0001000000;
  localparam logic [9:0] WBS  = 10'b0000100000;
  localparam logic [9:0] PINC = 10'b0000010000;
  localparam logic [9:0] PLD  = 10'b0000001000;
  localparam logic [9:0] RFWE = 10'b0000000100;
  localparam logic [9:0] ILL  = 10'b0000000010;
  localparam logic [9:0] HLT  = 10'b0000000001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic zero = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
  logic imem_req, dmem_req, dmem_we, ir_load, pc_inc, pc_load, rf_we;
  logic wb_sel, halted, bus_err, illegal;
  logic [2:0] alu_op, state;
  logic [CW-1:0] instr_count;
  logic [9:0] flags;

  int errors = 0, checks = 0;
  int cnt_m = 0;
  bit be_m = 0;

  cpu_ctrl_fsm #(.OPC_W(4), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .rf_we(rf_we),
    .alu_op(alu_op), .wb_sel(wb_sel), .halted(halted), .bus_err(bus_err),
    .illegal(illegal), .instr_count(instr_count), .state(state)
  );

  assign flags = {imem_req, ir_load, dmem_req, dmem_we, wb_sel,
                  pc_inc, pc_load, rf_we, illegal, halted};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  // One clock: drive acks, check combinational outputs mid-cycle, advance the
  // model, cross the edge, then check the registered counters.
  task automatic cyc(input logic [2:0] es, input logic [9:0] ef, input int ea,
                     input bit ret, input bit to, input bit ia, input bit da,
                     input string tag);
    imem_ack = ia;
    dmem_ack = da;
    #1;
    checks++;
    assert (state === es) else begin
      errors++; $error("FAIL %s state: got %0d want %0d", tag, state, es);
    end
    checks++;
    assert (flags === ef) else begin
      errors++; $error("FAIL %s flags: got %b want %b", tag, flags, ef);
    end
    if (ea >= 0) begin
      checks++;
      assert (alu_op === 3'(ea)) else begin
        errors++; $error("FAIL %s alu_op: got %0d want %0d", tag, alu_op, ea);
      end
    end
    if (ret) cnt_m = (cnt_m + 1) % (1 << CW);
    if (to) be_m = 1;
    @(posedge clk); #1;
    checks++;
    assert (instr_count === CW'(cnt_m)) else begin
      errors++; $error("FAIL %s instr_count: got %0d want %0d", tag, instr_count, cnt_m);
    end
    checks++;
    assert (bus_err === be_m) else begin
      errors++; $error("FAIL %s bus_err: got %0d want %0d", tag, bus_err, be_m);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    for (int i = 0; i < n; i++) begin
      imem_ack = 1'($urandom); dmem_ack = 1'($urandom);
      #1;
      checks++;
      assert ((flags & ~HLT) === 10'd0) else begin
        errors++; $error("FAIL reset_strobes: got %b want %b", flags & ~HLT, 10'd0);
      end
      @(posedge clk); #1;
    end
    cnt_m = 0; be_m = 0;
    checks++;
    assert ({state, instr_count, bus_err, halted} === {3'd0, CW'(0), 1'b0, 1'b0}) else begin
      errors++;
      $error("FAIL reset_state: got st=%0d cnt=%0d be=%0d h=%0d want 0/0/0/0",
             state, instr_count, bus_err, halted);
    end
    rst = 1'b1;
  endtask

  task automatic halt_cyc(input int n);
    for (int i = 0; i < n; i++)
      cyc(3'd5, HLT, -1, 0, 0, 1'($urandom), 1'($urandom), "halt");
  endtask

  // Expected trace for one instruction: df/dm are the number of wait cycles
  // before imem_ack/dmem_ack; a delay of TO or more means the ack never comes.
  task automatic run_instr(input int op, input int df, input int dm, input bit z);
    bit alu, ld, st, ill;
    logic [9:0] ef;
    opcode = 4'(op);
    zero = z;
    alu = (op >= 1 && op <= 7);
    ld = (op == 8); st = (op == 9);
    ill = (op >= 12 && op <= 14);
    for (int k = 0; k <= df && k < TO; k++)
      cyc(3'd0, IREQ | ((k == df) ? IRLD : 10'd0), -1, 0, (k == TO - 1) && (df >= TO),
          k == df, 0, "fetch");
    if (df >= TO) return;
    cyc(3'd1, 10'd0, -1, 0, 0, 0, 0, "decode");
    if (op == 10)      ef = PLD;
    else if (op == 11) ef = z ? PLD : PINC;
    else if (alu || ld || st || op == 15) ef = 10'd0;
    else               ef = PINC | (ill ? ILL : 10'd0);
    cyc(3'd2, ef, alu ? ((op >= 6) ? 5 : op - 1) : -1, !(alu || ld || st), 0, 0, 0, "exec");
    if (op == 15 || !(alu || ld || st)) return;
    if (ld || st) begin
      for (int k = 0; k <= dm && k < TO; k++)
        cyc(3'd3, DREQ | (st ? DWE : 10'd0) | (ld ? WBS : 10'd0) |
                  ((st && k == dm) ? PINC : 10'd0),
            -1, st && k == dm, (k == TO - 1) && (dm >= TO), 0, k == dm, "mem");
      if (dm >= TO || st) return;
    end
    cyc(3'd4, RFWE | PINC | (ld ? WBS : 10'd0), -1, 1, 0, 0, 0, "wb");
  endtask

  initial begin
    do_reset(2);
    // directed: arithmetic, memory handshakes, branches, illegal op
    run_instr(1, 0, 0, 0);
    run_instr(8, 0, 3, 0);
    run_instr(9, 0, 3, 0);
    run_instr(11, 0, 0, 1);
    run_instr(11, 0, 0, 0);
    run_instr(10, 1, 0, 0);
    run_instr(13, 0, 0, 0);
    run_instr(7, 2, 0, 0);
    // ack in the last allowed cycle still completes
    run_instr(1, TO - 1, 0, 0);
    run_instr(8, 0, TO - 1, 0);
    // random instruction mix; long enough to wrap the 4-bit counter
    for (int i = 0; i < 40; i++)
      run_instr($urandom_range(0, 14), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom));
    // reset while a data request is pending
    opcode = 4'h8;
    cyc(3'd0, IREQ | IRLD, -1, 0, 0, 1, 0, "rm_fetch");
    cyc(3'd1, 10'd0, -1, 0, 0, 0, 0, "rm_decode");
    cyc(3'd2, 10'd0, -1, 0, 0, 0, 0, "rm_exec");
    cyc(3'd3, DREQ | WBS, -1, 0, 0, 0, 0, "rm_mem");
    do_reset(1);
    // HLT retires once then stays halted
    run_instr(2, 0, 0, 0);
    run_instr(15, 0, 0, 0);
    halt_cyc(20);
    do_reset(1);
    // fetch timeout
    run_instr(1, 20, 0, 0);
    halt_cyc(5);
    do_reset(1);
    // data timeout on a store
    run_instr(9, 0, 20, 0);
    halt_cyc(3);
    do_reset(1);
    run_instr(4, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
Multi-cycle control unit for the 8-bit CPU. It sequences fetch/decode/execute/memory/writeback. It drives the PC enables, the instruction-register load, the register-file write enable, the ALU op select and the instruction/data memory request handshakes. It sits in cpu_top between the instruction register and the datapath (pc, rf, ALU), and also provides a memory-timeout watchdog and a retired-instruction counter.

Parameters:
OPC_W, 4, opcode width taken from instr[15:12]
TIMEOUT, 15, maximum cycles a memory request may wait for ack before bus error
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-low reset (sampled on rising clk; 0 = reset)
opcode  in  OPC_W  current instruction opcode from IR
zero  in  1  ALU zero flag (registered in datapath)
imem_ack  in  1  instruction memory data valid
dmem_ack  in  1  data memory access complete
imem_req  out  1  instruction fetch request
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write (valid with dmem_req)
ir_load  out  1  load IR from instruction bus
pc_inc  out  1  PC <= PC + 1
pc_load  out  1  PC <= jump target
rf_we  out  1  register-file write enable for dest
alu_op  out  3  ALU function: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 PASS_B
wb_sel  out  1  write-back source: 0 ALU/imm, 1 data memory
halted  out  1  core halted
bus_err  out  1  sticky memory-timeout flag
illegal  out  1  one-cycle pulse on undefined opcode
instr_count  out  CNT_W  retired-instruction count
state  out  3  current FSM state (debug)

Behaviour:
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 MOV, 7 LDI, 8 LD, 9 ST, A JMP, B JZ, F HLT. Opcodes C–E are illegal and execute as NOP with an illegal pulse in EXEC.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- Reset (rst=0 at an edge): state=FETCH, timeout counter=0, instr_count=0, bus_err=0, halted=0. All pulse/req outputs are 0 during the reset cycle. Reset mid-request drops req on the next edge, with no completion.
- FETCH: imem_req=1. When imem_ack=1 at the edge: ir_load=1 (combinational, same cycle), next state DECODE. Otherwise stay.
- DECODE: one cycle with no outputs, then EXEC.
- EXEC:
  - ALU ops and MOV/LDI: alu_op valid (MOV/LDI use PASS_B), then WB.
  - LD/ST: MEM.
  - JMP: pc_load=1, then FETCH.
  - JZ: if zero, pc_load=1, else pc_inc=1, then FETCH.
  - NOP/illegal: pc_inc=1, then FETCH.
  - HLT: HALT.
- MEM: dmem_req=1; dmem_we=1 for ST; wb_sel=1 for LD. On dmem_ack, LD goes to WB; ST asserts pc_inc=1 and goes to FETCH.
- WB: rf_we=1, pc_inc=1, wb_sel as set in MEM (0 for ALU ops), then FETCH.
- HALT: absorbing. halted=1 and all other strobes 0 until reset.
- Minimum cycles per instruction with ack in the first request cycle:
  - ALU/MOV/LDI: 4
  - JMP/JZ/NOP: 3
  - LD: 5
  - ST: 4
- instr_count increments by 1 in the cycle an instruction completes: the last EXEC/MEM/WB cycle, including HLT entry. It wraps from 2^CNT_W-1 to 0.
- Timeout: the counter resets on entry to FETCH/MEM and increments each cycle the request is pending without ack. An ack in the same cycle the count reaches TIMEOUT wins. Without ack at TIMEOUT, bus_err is set (sticky) and the next state is HALT.
- pc_inc and pc_load are never asserted together. rf_we is never asserted outside WB.

Decomposition:
- cpu_pkg holds:
  - opcode localparams (OP_NOP … OP_HLT)
  - state encodings (S_FETCH … S_HALT)
  - ALU op codes (ALU_ADD … ALU_PASS)
- One sub-module, cpu_mem_watchdog: the timeout counter, with inputs req and ack and output expired.
- The FSM next-state and output decode live in cpu_ctrl_fsm.

Test Plan:
- Reset/ADD: hold rst=0 for 2 cycles, release, imem_ack=1 always, opcode=1 → state 0,1,2,4,0. Cycle 1 has ir_load=1, cycle 3 has alu_op=0, cycle 4 has rf_we=1 and pc_inc=1, and instr_count becomes 1.
- LD/ST handshake: opcode=8 with dmem_ack delayed 3 cycles → dmem_req high 4 cycles with dmem_we=0 and wb_sel=1, then WB with rf_we=1. Repeating with opcode=9 gives dmem_we=1, pc_inc in the ack cycle, and no rf_we.
- Branches: opcode=B with zero=1 → one pc_load pulse and no pc_inc. With zero=0 → one pc_inc. Opcode=A → pc_load. Each instruction takes 3 cycles.
- Timeout: TIMEOUT=15 with imem_ack held 0 → after 15 pending cycles bus_err=1 and the state goes to HALT (5). halted stays 1 and imem_req stays 0 until rst=0.
- HLT/illegal: opcode=D → illegal pulses once in EXEC, then pc_inc. Opcode=F → halted=1 with no further imem_req for 20 cycles, and instr_count is incremented exactly once for HLT.
- Reset mid-MEM: assert rst=0 while dmem_req=1 → next edge gives dmem_req=0, state=FETCH, instr_count=0, bus_err=0.
